falling_piece_ctrl: RTL
=======================

Name: falling_piece_ctrl

Overview:
Drives the active falling tetromino on the 10x20 playfield. It spawns pieces, applies gravity on frame ticks, and applies left, right and rotate requests with wall checks. It publishes the four square positions (sq_1..sq_4 col/row) to the board block and consumes that block's registered collision flag to decide lock, respawn or game over. It is the producer side of the square-position/collision interface.

Parameters:
COLS, 10, playfield columns (legal col 0..COLS-1)
ROWS, 20, playfield rows (legal row 0..ROWS-1, row 0 at top)
SPAWN_COL, 4, pivot column at spawn
FALL_FRAMES, 30, frame_ticks per gravity step
DROP_FRAMES, 2, frame_ticks per gravity step while soft_drop is held

Ports:
pclk  in  1  pixel clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (vsync-derived)
move_left  in  1  one-cycle request: shift piece one column left
move_right  in  1  one-cycle request: shift piece one column right
rotate  in  1  one-cycle request: rotate piece clockwise
soft_drop  in  1  level: use DROP_FRAMES instead of FALL_FRAMES
collision  in  1  from board; registered, valid 1 cycle after sq_* change
sq_1_col..sq_4_col  out  5 each  square columns
sq_1_row..sq_4_row  out  5 each  square rows
piece_type  out  3  0=I 1=O 2=T 3=S 4=Z 5=J 6=L
lock  out  1  one-cycle pulse: board must latch current squares
game_over  out  1  sticky until reset

Behaviour:
- Reset (async, rst_n=0): all sq_* = 0, piece_type = 0, lock = 0, game_over = 0, rot = 0, fall counter = 0, LFSR = 3'b001, state = SPAWN. All outputs are registered.
- LFSR: 3-bit maximal, feedback x^3+x^2+1, steps every cycle; values 1..7; type = lfsr-1.
- Shape offsets (dx,dy) at rot0, in sq_1..sq_4 order:
  - I (-1,0)(0,0)(1,0)(2,0)
  - O (0,0)(1,0)(0,1)(1,1)
  - T (-1,0)(0,0)(1,0)(0,1)
  - S (0,0)(1,0)(-1,1)(0,1)
  - Z (-1,0)(0,0)(0,1)(1,1)
  - J (-1,0)(0,0)(1,0)(1,1)
  - L (-1,0)(0,0)(1,0)(-1,1)
- Rotation: each clockwise step maps (dx,dy) to (-dy,dx); rot is 2-bit and wraps 3 to 0. O ignores rot.
- Square position = pivot + offset, computed in 6-bit signed. A candidate position is legal only if every square satisfies 0<=col<COLS and 0<=row<ROWS.
- State SPAWN (1 cycle): piece_type = lfsr-1, rot = 0, pivot = (SPAWN_COL,0), sq_* updated, first_check = 1, go to SETTLE.
- State SETTLE (1 cycle): waits for the board's registered collision to reflect the new sq_*, then goes to CHECK.
- State CHECK:
  - collision=1: lock=1 for this cycle. If first_check, go to OVER; else go to SPAWN.
  - collision=0: first_check = 0, go to FALL.
- State FALL: evaluated each cycle in this priority order:
  1. frame_tick: counter++. When counter reaches the limit minus 1 (limit = DROP_FRAMES if soft_drop else FALL_FRAMES), clear counter and attempt pivot row+1. Any move request in the same cycle is discarded.
     - If row+1 is illegal for any square (floor): lock=1 and go to SPAWN (same as collision).
     - Otherwise update sq_* and go to SETTLE.
  2. rotate, then move_left, then move_right: at most one request is applied per cycle. If the candidate position is legal, update sq_* and rot/pivot and go to SETTLE. If illegal, the request is dropped with no change and the state stays FALL.
  - Requests arriving in SPAWN, SETTLE, CHECK or OVER are ignored (not queued).
- Lateral moves and rotations are checked against walls only; the board reports only downward collision.
- State OVER: sq_* frozen, game_over=1, all inputs ignored until rst_n asserts.
- Reset asserted mid-operation returns to reset values immediately and asynchronously.

Test Plan:
- Release reset with collision=0 -> one cycle later piece_type=0; sq=(3,0),(4,0),(5,0),(6,0); after SETTLE and CHECK the state is FALL; lock=0.
- Set FALL_FRAMES=2, pulse frame_tick twice -> on the cycle after the 2nd tick all rows=1, cols unchanged; a 1st tick alone causes no change.
- I piece at pivot col 4, four move_left pulses spaced 3 cycles apart -> pivot col 3,2,1, then sq_1 col=0; the 4th pulse is rejected and sq_* are unchanged.
- I piece at row 0, rotate -> rejected (row -1). Drop once, then rotate -> sq=(4,0),(4,1),(4,2),(4,3), and rotate with move_left in the same cycle applies rotate only.
- After one drop, hold collision=1 during CHECK -> lock high exactly 1 cycle, SPAWN next cycle, piece_type matches the LFSR model. Also drive an O piece to row 18 with collision=0 and issue a tick -> floor lock pulse and respawn.
- Keep collision=1 from spawn -> lock pulse, then game_over=1 stays high across 10 frame_ticks and move pulses. Pulse rst_n low mid-fall -> all outputs 0 asynchronously, and SPAWN follows release.

Source files
------------

// File: rtl/falling_piece_ctrl.sv
// Active tetromino controller: spawns pieces, applies gravity and player moves
// with wall checks, and publishes the four square positions to the board block.
`timescale 1ns/1ps

module falling_piece_ctrl #(
   parameter int COLS        = 10,
   parameter int ROWS        = 20,
   parameter int SPAWN_COL   = 4,
   parameter int FALL_FRAMES = 30,
   parameter int DROP_FRAMES = 2
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       rotate,
   input  logic       soft_drop,
   input  logic       collision,
   output logic [4:0] sq_1_col,
   output logic [4:0] sq_1_row,
   output logic [4:0] sq_2_col,
   output logic [4:0] sq_2_row,
   output logic [4:0] sq_3_col,
   output logic [4:0] sq_3_row,
   output logic [4:0] sq_4_col,
   output logic [4:0] sq_4_row,
   output logic [2:0] piece_type,
   output logic       lock,
   output logic       game_over
);

   // state  | meaning
   // SPAWN  | load a new piece from the LFSR at the spawn pivot
   // SETTLE | wait one cycle for the board's registered collision flag
   // CHECK  | sample collision: lock/respawn, game over, or continue falling
   // FALL   | gravity counting and player requests
   // OVER   | frozen until reset
   typedef enum logic [2:0] {SPAWN, SETTLE, CHECK, FALL, OVER} state_t;

   typedef struct packed {
      logic [3:0][5:0] col;
      logic [3:0][5:0] row;
      logic            ok;
   } cand_t;

   localparam logic [5:0] Z  = 6'd0;
   localparam logic [5:0] P1 = 6'd1;
   localparam logic [5:0] P2 = 6'd2;
   localparam logic [5:0] N1 = 6'h3F;

   state_t          state;
   logic [2:0]      lfsr;
   logic [1:0]      rot;
   logic [4:0]      pivot_col;
   logic [4:0]      pivot_row;
   logic            first_check;
   logic [7:0]      fall_cnt;
   logic [3:0][4:0] sq_col;
   logic [3:0][4:0] sq_row;

   logic [2:0]      cand_type;
   logic [1:0]      cand_rot;
   logic [5:0]      cand_pc;
   logic [5:0]      cand_pr;
   cand_t           cand;
   logic [7:0]      limit;

   // Rot-0 offset {dx, dy} of square i, two's complement 6-bit.
   function automatic logic [11:0] base_offset(input logic [2:0] t, input logic [1:0] i);
      logic [11:0] o;
      o = {Z, Z};
      case (t)
         3'd1: case (i) 2'd0: o = {Z, Z};  2'd1: o = {P1, Z}; 2'd2: o = {Z, P1};  default: o = {P1, P1}; endcase
         3'd2: case (i) 2'd0: o = {N1, Z}; 2'd1: o = {Z, Z};  2'd2: o = {P1, Z};  default: o = {Z, P1};  endcase
         3'd3: case (i) 2'd0: o = {Z, Z};  2'd1: o = {P1, Z}; 2'd2: o = {N1, P1}; default: o = {Z, P1};  endcase
         3'd4: case (i) 2'd0: o = {N1, Z}; 2'd1: o = {Z, Z};  2'd2: o = {Z, P1};  default: o = {P1, P1}; endcase
         3'd5: case (i) 2'd0: o = {N1, Z}; 2'd1: o = {Z, Z};  2'd2: o = {P1, Z};  default: o = {P1, P1}; endcase
         3'd6: case (i) 2'd0: o = {N1, Z}; 2'd1: o = {Z, Z};  2'd2: o = {P1, Z};  default: o = {N1, P1}; endcase
         default: case (i) 2'd0: o = {N1, Z}; 2'd1: o = {Z, Z}; 2'd2: o = {P1, Z}; default: o = {P2, Z}; endcase
      endcase
      return o;
   endfunction

   // Negative coordinates wrap to 58..63, so one unsigned compare covers both walls.
   function automatic cand_t place(input logic [2:0] t, input logic [1:0] r,
                                   input logic [5:0] pc, input logic [5:0] pr);
      cand_t       c;
      logic [11:0] o;
      logic [5:0]  dx, dy, tmp;
      c.ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         o  = base_offset(t, 2'(i));
         dx = o[11:6];
         dy = o[5:0];
         if (t != 3'd1) begin
            for (int k = 0; k < 3; k++) begin
               if (k < int'(r)) begin
                  tmp = dx;
                  dx  = Z - dy;
                  dy  = tmp;
               end
            end
         end
         c.col[i] = pc + dx;
         c.row[i] = pr + dy;
         if (c.col[i] >= 6'(COLS) || c.row[i] >= 6'(ROWS))
            c.ok = 1'b0;
      end
      return c;
   endfunction

   function automatic logic [3:0][4:0] low5(input logic [3:0][5:0] v);
      logic [3:0][4:0] r;
      for (int i = 0; i < 4; i++)
         r[i] = v[i][4:0];
      return r;
   endfunction

   // One shared placement evaluator; its inputs follow the request priority.
   always_comb begin
      cand_type = piece_type;
      cand_rot  = rot;
      cand_pc   = {1'b0, pivot_col};
      cand_pr   = {1'b0, pivot_row};
      if (state == SPAWN) begin
         cand_type = lfsr - 3'd1;
         cand_rot  = 2'd0;
         cand_pc   = 6'(SPAWN_COL);
         cand_pr   = 6'd0;
      end else if (frame_tick) begin
         cand_pr = {1'b0, pivot_row} + 6'd1;
      end else if (rotate) begin
         cand_rot = rot + 2'd1;
      end else if (move_left) begin
         cand_pc = {1'b0, pivot_col} - 6'd1;
      end else if (move_right) begin
         cand_pc = {1'b0, pivot_col} + 6'd1;
      end
   end

   assign cand  = place(cand_type, cand_rot, cand_pc, cand_pr);
   assign limit = soft_drop ? 8'(DROP_FRAMES) : 8'(FALL_FRAMES);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SPAWN;
         lfsr        <= 3'b001;
         rot         <= 2'd0;
         pivot_col   <= 5'd0;
         pivot_row   <= 5'd0;
         first_check <= 1'b0;
         fall_cnt    <= 8'd0;
         sq_col      <= '0;
         sq_row      <= '0;
         piece_type  <= 3'd0;
         lock        <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
         lock <= 1'b0;
         case (state)
            SPAWN: begin
               piece_type  <= cand_type;
               rot         <= 2'd0;
               pivot_col   <= 5'(SPAWN_COL);
               pivot_row   <= 5'd0;
               sq_col      <= low5(cand.col);
               sq_row      <= low5(cand.row);
               first_check <= 1'b1;
               state       <= SETTLE;
            end
            SETTLE: state <= CHECK;
            CHECK: begin
               if (collision) begin
                  lock <= 1'b1;
                  if (first_check) begin
                     game_over <= 1'b1;
                     state     <= OVER;
                  end else begin
                     state <= SPAWN;
                  end
               end else begin
                  first_check <= 1'b0;
                  state       <= FALL;
               end
            end
            FALL: begin
               if (frame_tick) begin
                  if (fall_cnt >= limit - 8'd1) begin
                     fall_cnt <= 8'd0;
                     if (cand.ok) begin
                        pivot_row <= cand_pr[4:0];
                        sq_col    <= low5(cand.col);
                        sq_row    <= low5(cand.row);
                        state     <= SETTLE;
                     end else begin
                        lock  <= 1'b1;
                        state <= SPAWN;
                     end
                  end else begin
                     fall_cnt <= fall_cnt + 8'd1;
                  end
               end else if ((rotate || move_left || move_right) && cand.ok) begin
                  rot       <= cand_rot;
                  pivot_col <= cand_pc[4:0];
                  sq_col    <= low5(cand.col);
                  sq_row    <= low5(cand.row);
                  state     <= SETTLE;
               end
            end
            OVER: game_over <= 1'b1;
            default: state <= SPAWN;
         endcase
      end
   end

   assign sq_1_col = sq_col[0];
   assign sq_1_row = sq_row[0];
   assign sq_2_col = sq_col[1];
   assign sq_2_row = sq_row[1];
   assign sq_3_col = sq_col[2];
   assign sq_3_row = sq_row[2];
   assign sq_4_col = sq_col[3];
   assign sq_4_row = sq_row[3];

endmodule
